// File: rtl/fp_align_pkg.sv
// Shared widths, FSM state type and mantissa packing helper for the FP adder alignment stage.
package fp_align_pkg;

    localparam int MANT_W  = 24;
    localparam int GRS_W   = 3;
    localparam int ALIGN_W = 27;
    localparam int EXP_W   = 8;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } align_state_e;

    // Hidden bit on top, three zero guard/round/sticky bits underneath.
    function automatic logic [ALIGN_W-1:0] build_mant(input logic hidden, input logic [MANT_W-2:0] frac);
        return {hidden, frac, {GRS_W{1'b0}}};
    endfunction

endpackage

// File: rtl/fp_mantissa_aligner_sticky_shift_right.sv
// Combinational right shifter that folds every bit shifted out into bit 0 (sticky).
module sticky_shift_right
    import fp_align_pkg::*;
(
    input  logic [ALIGN_W-1:0] data,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [ALIGN_W-1:0] result
);

    logic [ALIGN_W-1:0] lost_mask;
    logic               sticky;

    always_comb begin
        lost_mask = ~({ALIGN_W{1'b1}} << shamt);
        sticky    = |(data & lost_mask);
        result    = (data >> shamt) | {{(ALIGN_W-1){1'b0}}, sticky};
    end

endmodule

// File: rtl/fp_mantissa_aligner.sv
// Mantissa alignment stage: steers the larger operand to a fixed lane and right-shifts
// the smaller one over several cycles with sticky preservation.
module fp_mantissa_aligner
    import fp_align_pkg::*;
#(
    parameter int SHIFT_PER_CYCLE = 8,
    parameter int MAX_SHIFT       = 27
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [31:0]         operand_a_i,
    input  logic [31:0]         operand_b_i,
    input  logic [EXP_W-1:0]    exponent_diff_i,
    input  logic                swap_i,
    input  logic [1:0]          hidden_i,
    input  logic                equals_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [ALIGN_W-1:0]  mant_large_o,
    output logic [ALIGN_W-1:0]  mant_small_o,
    output logic [EXP_W-1:0]    exp_o,
    output logic                sign_large_o,
    output logic                sign_small_o,
    output logic                equals_o
);

    localparam logic [SHAMT_W-1:0] STEP_MAX  = SHAMT_W'(SHIFT_PER_CYCLE);
    localparam logic [SHAMT_W-1:0] SHAMT_SAT = SHAMT_W'(MAX_SHIFT);
    localparam logic [EXP_W:0]     DIFF_SAT  = (EXP_W+1)'(MAX_SHIFT);

    align_state_e       state, next_state;
    logic [31:0]        op_large;
    logic [MANT_W-2:0]  frac_small;
    logic               sign_small;
    logic               hidden_large, hidden_small;
    logic [EXP_W:0]     diff_adj;
    logic [SHAMT_W-1:0] eff_shift, remaining, step;
    logic [ALIGN_W-1:0] mant_small_q, mant_shifted;

    always_comb begin
        op_large     = swap_i ? operand_b_i : operand_a_i;
        frac_small   = swap_i ? operand_a_i[MANT_W-2:0] : operand_b_i[MANT_W-2:0];
        sign_small   = swap_i ? operand_a_i[31] : operand_b_i[31];
        hidden_large = swap_i ? hidden_i[0] : hidden_i[1];
        hidden_small = swap_i ? hidden_i[1] : hidden_i[0];
    end

    // A denormal's exponent field reads 0 but behaves as 1, so a normal/denormal pair shifts one less.
    always_comb begin
        diff_adj = {1'b0, exponent_diff_i};
        if (hidden_large && !hidden_small && (exponent_diff_i != '0)) begin
            diff_adj = diff_adj - (EXP_W+1)'(1);
        end
        eff_shift = (diff_adj > DIFF_SAT) ? SHAMT_SAT : diff_adj[SHAMT_W-1:0];
    end

    always_comb begin
        step = (remaining > STEP_MAX) ? STEP_MAX : remaining;
    end

    sticky_shift_right u_shift (
        .data   (mant_small_q),
        .shamt  (step),
        .result (mant_shifted)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (in_valid_i) begin
                    next_state = (equals_i || (eff_shift == '0)) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (remaining == step) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mant_large_o <= '0;
            mant_small_q <= '0;
            exp_o        <= '0;
            sign_large_o <= 1'b0;
            sign_small_o <= 1'b0;
            equals_o     <= 1'b0;
            remaining    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        mant_large_o <= build_mant(hidden_large, op_large[MANT_W-2:0]);
                        mant_small_q <= build_mant(hidden_small, frac_small);
                        exp_o        <= op_large[30:23];
                        sign_large_o <= op_large[31];
                        sign_small_o <= sign_small;
                        equals_o     <= equals_i;
                        remaining    <= equals_i ? '0 : eff_shift;
                    end
                end
                SHIFT: begin
                    mant_small_q <= mant_shifted;
                    remaining    <= remaining - step;
                end
                default: ;
            endcase
        end
    end

    assign mant_small_o = mant_small_q;
    assign in_ready_o   = (state == IDLE);
    assign out_valid_o  = (state == DONE);

endmodule

// File: tb/tb_fp_mantissa_aligner.sv
// Directed self-checking bench for fp_mantissa_aligner with hand-computed expected values.
module tb_fp_mantissa_aligner;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] operand_a_i = '0;
    logic [31:0] operand_b_i = '0;
    logic [7:0]  exponent_diff_i = '0;
    logic        swap_i = 1'b0;
    logic [1:0]  hidden_i = '0;
    logic        equals_i = 1'b0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [26:0] mant_large_o;
    logic [26:0] mant_small_o;
    logic [7:0]  exp_o;
    logic        sign_large_o;
    logic        sign_small_o;
    logic        equals_o;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    fp_mantissa_aligner #(.SHIFT_PER_CYCLE(8), .MAX_SHIFT(27)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .operand_a_i     (operand_a_i),
        .operand_b_i     (operand_b_i),
        .exponent_diff_i (exponent_diff_i),
        .swap_i          (swap_i),
        .hidden_i        (hidden_i),
        .equals_i        (equals_i),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .mant_large_o    (mant_large_o),
        .mant_small_o    (mant_small_o),
        .exp_o           (exp_o),
        .sign_large_o    (sign_large_o),
        .sign_small_o    (sign_small_o),
        .equals_o        (equals_o)
    );

    // Presents one operation for a single accept edge, then counts edges until out_valid_o (21 = timeout).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [7:0] diff,
                          input logic swp, input logic [1:0] hid, input logic eq, output int lat);
        operand_a_i = a;
        operand_b_i = b;
        exponent_diff_i = diff;
        swap_i = swp;
        hidden_i = hid;
        equals_i = eq;
        in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        lat = 1;
        while (!out_valid_o && lat <= 20) begin
            @(posedge clk_i); #1;
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (in_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready_o); end
        checks++; if (out_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid_o); end
        checks++; if (mant_large_o !== 27'h0 || mant_small_o !== 27'h0) begin failures++; $display("[TB] FAIL reset_mant: got %h/%h expected 0/0", mant_large_o, mant_small_o); end
        checks++; if ({exp_o, sign_large_o, sign_small_o, equals_o} !== 11'h0) begin failures++; $display("[TB] FAIL reset_misc: got exp=%h signs=%b%b eq=%b expected all 0", exp_o, sign_large_o, sign_small_o, equals_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_basic();
        int lat;
        run_op(32'h40400000, 32'h3F800000, 8'd1, 1'b0, 2'b11, 1'b0, lat);
        checks++; if (lat !== 2) begin failures++; $display("[TB] FAIL basic_latency: got %0d expected 2", lat); end
        checks++; if (mant_large_o !== 27'h6000000) begin failures++; $display("[TB] FAIL basic_mant_large: got %h expected 6000000", mant_large_o); end
        checks++; if (mant_small_o !== 27'h2000000) begin failures++; $display("[TB] FAIL basic_mant_small: got %h expected 2000000", mant_small_o); end
        checks++; if (exp_o !== 8'h80) begin failures++; $display("[TB] FAIL basic_exp: got %h expected 80", exp_o); end
        checks++; if ({sign_large_o, sign_small_o} !== 2'b00) begin failures++; $display("[TB] FAIL basic_signs: got %b%b expected 00", sign_large_o, sign_small_o); end
        checks++; if (in_ready_o !== 1'b0) begin failures++; $display("[TB] FAIL basic_ready_in_done: got %b expected 0", in_ready_o); end
        release_result();
    endtask

    task automatic test_swap();
        int lat;
        run_op(32'h3F800000, 32'h40400000, 8'd1, 1'b1, 2'b11, 1'b0, lat);
        checks++; if (lat !== 2) begin failures++; $display("[TB] FAIL swap_latency: got %0d expected 2", lat); end
        checks++; if (mant_large_o !== 27'h6000000) begin failures++; $display("[TB] FAIL swap_mant_large: got %h expected 6000000", mant_large_o); end
        checks++; if (mant_small_o !== 27'h2000000) begin failures++; $display("[TB] FAIL swap_mant_small: got %h expected 2000000", mant_small_o); end
        checks++; if (exp_o !== 8'h80) begin failures++; $display("[TB] FAIL swap_exp: got %h expected 80", exp_o); end
        release_result();
    endtask

    task automatic test_saturation();
        int lat;
        run_op(32'h4E800000, 32'h3F800000, 8'd30, 1'b0, 2'b11, 1'b0, lat);
        checks++; if (lat !== 5) begin failures++; $display("[TB] FAIL sat_latency: got %0d expected 5", lat); end
        checks++; if (mant_small_o !== 27'h0000001) begin failures++; $display("[TB] FAIL sat_mant_small: got %h expected 0000001", mant_small_o); end
        checks++; if (mant_large_o !== 27'h4000000) begin failures++; $display("[TB] FAIL sat_mant_large: got %h expected 4000000", mant_large_o); end
        checks++; if (exp_o !== 8'h9D) begin failures++; $display("[TB] FAIL sat_exp: got %h expected 9d", exp_o); end
        release_result();
    endtask

    task automatic test_multi_step_sticky();
        int lat;
        // 1.0 vs 2^-10 * (1 + 2^-23): shift 10 = 8 + 2, the lone low bit must survive as sticky.
        run_op(32'h3F800000, 32'h3A800001, 8'd10, 1'b0, 2'b11, 1'b0, lat);
        checks++; if (lat !== 3) begin failures++; $display("[TB] FAIL sticky_latency: got %0d expected 3", lat); end
        checks++; if (mant_small_o !== 27'h0010001) begin failures++; $display("[TB] FAIL sticky_mant_small: got %h expected 0010001", mant_small_o); end
        checks++; if (exp_o !== 8'h7F) begin failures++; $display("[TB] FAIL sticky_exp: got %h expected 7f", exp_o); end
        release_result();
    endtask

    task automatic test_denormal();
        int lat;
        run_op(32'h3F800000, 32'h00000001, 8'd127, 1'b0, 2'b10, 1'b0, lat);
        checks++; if (lat !== 5) begin failures++; $display("[TB] FAIL denorm_latency: got %0d expected 5", lat); end
        checks++; if (mant_small_o !== 27'h0000001) begin failures++; $display("[TB] FAIL denorm_mant_small: got %h expected 0000001", mant_small_o); end
        checks++; if (exp_o !== 8'h7F) begin failures++; $display("[TB] FAIL denorm_exp: got %h expected 7f", exp_o); end
        release_result();
        // Smallest normal vs a denormal: diff 1 minus the denormal adjustment leaves no shift.
        run_op(32'h00800000, 32'h00400000, 8'd1, 1'b0, 2'b10, 1'b0, lat);
        checks++; if (lat !== 1) begin failures++; $display("[TB] FAIL denorm_adj_latency: got %0d expected 1", lat); end
        checks++; if (mant_small_o !== 27'h2000000) begin failures++; $display("[TB] FAIL denorm_adj_mant_small: got %h expected 2000000", mant_small_o); end
        checks++; if (mant_large_o !== 27'h4000000 || exp_o !== 8'h01) begin failures++; $display("[TB] FAIL denorm_adj_large: got %h exp %h expected 4000000 exp 01", mant_large_o, exp_o); end
        release_result();
    endtask

    task automatic test_equals_backpressure();
        int lat;
        run_op(32'h3F800000, 32'h3F800000, 8'd0, 1'b0, 2'b11, 1'b1, lat);
        checks++; if (lat !== 1) begin failures++; $display("[TB] FAIL eq_latency: got %0d expected 1", lat); end
        checks++; if (equals_o !== 1'b1) begin failures++; $display("[TB] FAIL eq_flag: got %b expected 1", equals_o); end
        // A competing request during DONE must be ignored.
        operand_a_i = 32'h40400000;
        equals_i = 1'b0;
        in_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            checks++; if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0) begin failures++; $display("[TB] FAIL bp_handshake[%0d]: got valid=%b ready=%b expected 1/0", i, out_valid_o, in_ready_o); end
            checks++; if (mant_large_o !== 27'h4000000 || mant_small_o !== 27'h4000000 || equals_o !== 1'b1) begin failures++; $display("[TB] FAIL bp_stable[%0d]: got %h/%h eq=%b expected 4000000/4000000 eq=1", i, mant_large_o, mant_small_o, equals_o); end
        end
        in_valid_i = 1'b0;
        release_result();
        checks++; if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL bp_release: got ready=%b valid=%b expected 1/0", in_ready_o, out_valid_o); end
        // equals_i skips shifting even with a nonzero difference.
        run_op(32'h3F800000, 32'h3F800000, 8'd5, 1'b0, 2'b11, 1'b1, lat);
        checks++; if (lat !== 1) begin failures++; $display("[TB] FAIL eq_skip_latency: got %0d expected 1", lat); end
        checks++; if (mant_small_o !== 27'h4000000) begin failures++; $display("[TB] FAIL eq_skip_mant_small: got %h expected 4000000", mant_small_o); end
        release_result();
    endtask

    task automatic test_reset_in_shift();
        int lat;
        operand_a_i = 32'h4E800000;
        operand_b_i = 32'h3F800000;
        exponent_diff_i = 8'd30;
        swap_i = 1'b0;
        hidden_i = 2'b11;
        equals_i = 1'b0;
        in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        @(posedge clk_i); #2;
        checks++; if (in_ready_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_shift_busy: got ready=%b expected 0", in_ready_o); end
        rst_ni = 1'b0;
        #1;
        checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL rst_shift_async: got valid=%b ready=%b expected 0/1", out_valid_o, in_ready_o); end
        checks++; if (mant_small_o !== 27'h0 || mant_large_o !== 27'h0) begin failures++; $display("[TB] FAIL rst_shift_clear: got %h/%h expected 0/0", mant_large_o, mant_small_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        run_op(32'h40400000, 32'h3F800000, 8'd1, 1'b0, 2'b11, 1'b0, lat);
        checks++; if (lat !== 2 || mant_small_o !== 27'h2000000) begin failures++; $display("[TB] FAIL rst_recover: got lat=%0d small=%h expected lat=2 small=2000000", lat, mant_small_o); end
        release_result();
    endtask

    task automatic test_back_to_back();
        int lat;
        checks++; if (in_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready: got %b expected 1", in_ready_o); end
        // -1.0 as A, +3.0 as B with swap: larger is positive, smaller negative.
        run_op(32'hBF800000, 32'h40400000, 8'd1, 1'b1, 2'b11, 1'b0, lat);
        checks++; if (lat !== 2) begin failures++; $display("[TB] FAIL b2b_latency: got %0d expected 2", lat); end
        checks++; if ({sign_large_o, sign_small_o} !== 2'b01) begin failures++; $display("[TB] FAIL b2b_signs: got %b%b expected 01", sign_large_o, sign_small_o); end
        checks++; if (mant_large_o !== 27'h6000000 || mant_small_o !== 27'h2000000) begin failures++; $display("[TB] FAIL b2b_mant: got %h/%h expected 6000000/2000000", mant_large_o, mant_small_o); end
        release_result();
        run_op(32'h3F800000, 32'h3A800001, 8'd10, 1'b0, 2'b11, 1'b0, lat);
        checks++; if (lat !== 3 || mant_small_o !== 27'h0010001 || sign_small_o !== 1'b0) begin failures++; $display("[TB] FAIL b2b_second: got lat=%0d small=%h sign=%b expected 3/0010001/0", lat, mant_small_o, sign_small_o); end
        release_result();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_swap();
        test_saturation();
        test_multi_step_sticky();
        test_denormal();
        test_equals_backpressure();
        test_reset_in_shift();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
